pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width (instruction word plus PC+4).
REQ-002 SHALL have parameter EXC_W, default 5, meaning exception-code width; code 0 means "no exception".
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning the upstream stage offers a payload.
REQ-006 SHALL have port in_ready  output  1  meaning the stage accepts a payload this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  meaning the upstream payload.
REQ-008 SHALL have port in_exc  input  EXC_W  meaning the exception code carried from upstream.
REQ-009 SHALL have port stage_exc  input  EXC_W  meaning the exception raised by this stage for the incoming payload.
REQ-010 SHALL have port flush  input  1  meaning discard all held payloads (branch or exception redirect).
REQ-011 SHALL have port out_valid  output  1  meaning a payload is presented downstream.
REQ-012 SHALL have port out_ready  input  1  meaning downstream accepts the presented payload.
REQ-013 SHALL have port out_data  output  DATA_W  meaning the presented payload.
REQ-014 SHALL have port out_exc  output  EXC_W  meaning the presented exception code.

Function
REQ-015 SHALL hold two entries, main and skid, each a payload, an exception code and a valid bit.
REQ-016 SHALL drive in_ready = NOT skid.valid, straight from a flop with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = main.valid, and out_data/out_exc from main.
REQ-018 SHALL force out_data and out_exc to zero whenever main.valid = 0 (NOP bubble).
REQ-019 SHALL accept on in_valid AND in_ready, and retire on out_valid AND out_ready.
REQ-020 SHALL store exc = in_exc when in_exc != 0, else stage_exc (the older exception wins).
REQ-021 SHALL write an accepted payload into main when main is empty or retiring with skid empty, otherwise into skid.
REQ-022 SHALL move skid into main on a retire with skid valid, clearing skid in the same cycle.
REQ-023 SHALL handle a retire while skid is valid and a simultaneous accept as follows: skid moves to main, the accepted payload is not possible because in_ready = 0, and there is no loss.
REQ-024 SHALL add one cycle of latency: a payload accepted in cycle N appears on out_* in cycle N+1 when main was empty.
REQ-025 SHALL take flush synchronously at the highest priority: it clears both valid bits, zeroes the stored payloads and drops any same-cycle in_valid.
REQ-026 SHALL keep the sequence of retired payloads equal to the sequence of accepted payloads, with no duplication or reordering.

Reset
REQ-027 SHALL, while reset_n = 0, force main.valid = skid.valid = 0, all stored payload and exception bits = 0 and in_ready = 1, regardless of CLK.
REQ-028 SHALL, after reset_n is released mid-transfer, resume from empty, with no payload retired before a new accept.

Configuration
REQ-029 SHALL, when macro PIPE_STAGE_PERF_EN is defined, add output stall_cnt (32 bits) that counts cycles with out_valid = 1 AND out_ready = 0, saturates at 0xFFFFFFFF, and is cleared by reset and by flush.
REQ-030 SHALL, without PIPE_STAGE_PERF_EN, omit the port and its counter entirely.

Structure
REQ-031 SHALL place the default widths, the EXC_NONE = 0 constant and an entry struct (payload, exc, valid) in the shared pipeline package.
REQ-032 SHALL be implemented as a single module; the saturating counter MAY be the sub-module sat_counter.

Verification
REQ-033 SHALL cover: reset released, in_valid = 1 with in_data = 0x0000_0040_2409_0001 and out_ready = 1 -> out_valid = 1 and the same data one cycle later, in_ready held at 1.
REQ-034 SHALL cover: out_ready = 0 with three back-to-back payloads A, B, C -> A and B accepted, in_ready = 0 at the third, then out_ready = 1 -> A, B, C retired in order.
REQ-035 SHALL cover: flush asserted with both entries full and in_valid = 1 -> next cycle out_valid = 0, out_data = 0, in_ready = 1, and the dropped payload is never seen.
REQ-036 SHALL cover: in_exc = 0, stage_exc = 5'd12 -> out_exc = 12; in_exc = 5'd4, stage_exc = 5'd12 -> out_exc = 4.
REQ-037 SHALL cover: reset_n pulsed low between clock edges while holding payloads -> out_valid = 0 immediately, and the stage is empty after release.
REQ-038 SHALL cover (PIPE_STAGE_PERF_EN): 7 stalled cycles -> stall_cnt = 7, then flush -> stall_cnt = 0.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared pipeline widths, no-exception code and entry layout.
package pipe_stage_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int EXC_W_DEF  = 5;
  localparam int EXC_NONE   = 0;
  typedef struct packed {
    logic [DATA_W_DEF-1:0] payload;
    logic [EXC_W_DEF-1:0]  exc;
    logic                  valid;
  } entry_t;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: two-entry (main + skid) registered pipeline stage with flush and exception merge.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt output.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXC_W  = EXC_W_DEF
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  stage_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [EXC_W-1:0]  exc;
    logic              valid;
  } ent_t;
  ent_t main_q, main_d, skid_q, skid_d, in_ent;
  logic acc, ret;
  assign acc       = in_valid & ~skid_q.valid;
  assign ret       = main_q.valid & out_ready;
  assign in_ready  = ~skid_q.valid;
  assign out_valid = main_q.valid;
  assign out_data  = main_q.valid ? main_q.payload : '0;
  assign out_exc   = main_q.valid ? main_q.exc : '0;
  // the older (upstream) exception takes precedence over this stage's own
  assign in_ent = '{payload: in_data,
                    exc:     (in_exc != EXC_W'(EXC_NONE)) ? in_exc : stage_exc,
                    valid:   1'b1};
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else if (!main_q.valid || ret) begin
      main_d = skid_q.valid ? skid_q : acc ? in_ent : '0;
      skid_d = '0;
    end else if (acc) begin
      skid_d = in_ent;
    end
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d   = flush ? '0 : (main_q.valid & ~out_ready & ~&stall_q) ? stall_q + 32'd1 : stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed and random checks of pipe_stage against a two-deep FIFO model.
module tb_pipe_stage;
  logic        CLK = 0, reset_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [63:0] in_data = '0, out_data;
  logic [4:0]  in_exc = '0, stage_exc = '0, out_exc;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
`endif
  typedef struct {
    logic [63:0] d;
    logic [4:0]  e;
  } ent_t;
  ent_t        q[$];
  logic [31:0] stall_m = '0;
  int          chk = 0, err = 0;

  always #5 CLK = ~CLK;

  pipe_stage dut (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_exc(in_exc), .stage_exc(stage_exc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("out_data", out_data, n != 0 ? q[0].d : 64'd0);
    check("out_exc", 64'(out_exc), 64'(n != 0 ? q[0].e : 5'd0));
    check("in_ready", 64'(in_ready), 64'(n < 2));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
  endtask

  // model: a FIFO of depth two, updated with the inputs seen at the edge
  task automatic tick();
    int n;
    @(posedge CLK);
    n = q.size();
    if (!reset_n || flush) begin
      q.delete();
      stall_m = '0;
    end else begin
      if (n > 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back('{in_data, in_exc != 5'd0 ? in_exc : stage_exc});
    end
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] ie,
                       input logic [4:0] se, input logic r, input logic f);
    in_valid = v; in_data = d; in_exc = ie; stage_exc = se; out_ready = r; flush = f;
  endtask

  localparam logic [63:0] A = 64'hAAAA_0000_0000_0001, B = 64'hBBBB_0000_0000_0002,
                          C = 64'hCCCC_0000_0000_0003, D = 64'hDDDD_0000_0000_0004,
                          E = 64'hEEEE_0000_0000_0005, F = 64'hFFFF_0000_0000_0006;

  initial begin
    tick();
    tick();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1;
    tick();
    drive(1, 64'h0000_0040_2409_0001, 0, 0, 1, 0);
    tick();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", out_data, 64'h0000_0040_2409_0001);
    check("first_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(1, A, 0, 0, 0, 0);
    tick();
    check("bp_a_out", out_data, A);
    drive(1, B, 0, 0, 0, 0);
    tick();
    check("bp_skid_full", 64'(in_ready), 64'd0);
    drive(1, C, 0, 0, 0, 0);
    tick();
    check("bp_c_blocked", 64'(in_ready), 64'd0);
    check("bp_a_held", out_data, A);
    out_ready = 1;
    tick();
    check("bp_b_out", out_data, B);
    tick();
    check("bp_c_out", out_data, C);
    in_valid = 0;
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);
    drive(1, D, 0, 0, 0, 0);
    tick();
    drive(1, E, 0, 0, 0, 0);
    tick();
    drive(1, F, 0, 0, 0, 1);
    tick();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_data", out_data, 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    drive(1, A, 5'd0, 5'd12, 1, 0);
    tick();
    check("exc_stage", 64'(out_exc), 64'd12);
    drive(1, B, 5'd4, 5'd12, 1, 0);
    tick();
    check("exc_older", 64'(out_exc), 64'd4);
    drive(1, C, 0, 0, 0, 0);
    tick();
    drive(1, D, 0, 0, 0, 0);
    tick();
    #2 reset_n = 0;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_data", out_data, 64'd0);
    check("async_ready", 64'(in_ready), 64'd1);
    q.delete();
    stall_m = '0;
    #1 reset_n = 1;
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check("post_reset_empty", 64'(out_valid), 64'd0);
    tick();
`ifdef PIPE_STAGE_PERF_EN
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(1, E, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) tick();
    check("stall_seven", 64'(stall_cnt), 64'd7);
    flush = 1;
    tick();
    check("stall_flushed", 64'(stall_cnt), 64'd0);
    flush = 0;
`endif
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
            $urandom_range(0, 2) == 0 ? 5'($urandom) : 5'd0, 5'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
